// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, width helpers and saturation for the neuron MAC datapath
//
// Contents:
//   state_t    : drain FSM states (COLLECT, DRAIN)
//   clog2      : ceiling log2 usable in parameter expressions
//   acc_width  : accumulator width 2n + clog2(d), wide enough for d products without wrap
//   saturate   : clamp a signed value to the n-bit two's complement range
package nn_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int n, input int d);
    return 2 * n + clog2(d);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] s, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/result_buf.sv
// rtl/result_buf.sv - Q x N result register file, one write port, one async read port
//
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_idx   : write index
//   wr_data  : write data
//   rd_idx   : read index
//   rd_data  : combinational read data at rd_idx
module result_buf #(
  parameter int N     = 8,
  parameter int Q     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [N-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [N-1:0]     rd_data
);

  // Contents are not reset; entries are only read after being written.
  logic [N-1:0] mem [Q];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/neuron_mac_datapath.sv
// rtl/neuron_mac_datapath.sv - neuron MAC datapath: accumulate, saturate, buffer, drain
//
// Optional build macro: RELU_EN (negative converted results buffered as 0).
//
// Ports:
//   clk, rst            : clock; synchronous active-low reset
//   x_in, w_in          : input sample / weight, captured by write_x / write_w
//   write_x, write_w    : register load strobes
//   acc_write           : acc += x_reg * w_reg
//   clear_acc           : acc = 0 (with acc_write: acc = x_reg * w_reg)
//   res_write           : push converted acc into result buffer
//   done                : layer complete, start draining buffered results
//   out_valid, out_ready, out_data, out_last : result stream
//   busy                : high while draining
//   err                 : sticky, a res_write was dropped
module neuron_mac_datapath
  import nn_pkg::*;
#(
  parameter int N    = 8,
  parameter int d    = 4,
  parameter int Q    = 4,
  parameter int FRAC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] x_in,
  input  logic signed [N-1:0] w_in,
  input  logic                write_x,
  input  logic                write_w,
  input  logic                acc_write,
  input  logic                clear_acc,
  input  logic                res_write,
  input  logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_data,
  output logic                out_last,
  output logic                busy,
  output logic                err
);

  localparam int ACC_W = acc_width(N, d);
  localparam int CNT_W = clog2(Q + 1);
  localparam int IDX_W = (Q > 1) ? clog2(Q) : 1;

  logic signed [N-1:0]     x_reg;
  logic signed [N-1:0]     w_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [N-1:0]     res_val;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_after;
  logic [CNT_W-1:0] rd_idx;
  logic             wr_en;
  logic [N-1:0]     rd_data;

  assign prod     = x_reg * w_reg;
  assign prod_ext = ACC_W'(prod);

  // Accumulator path runs independently of the drain FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_reg <= '0;
      w_reg <= '0;
      acc   <= '0;
    end else begin
      if (write_x) x_reg <= x_in;
      if (write_w) w_reg <= w_in;
      if (clear_acc) acc <= acc_write ? prod_ext : '0;
      else if (acc_write) acc <= acc + prod_ext;
    end
  end

  always_comb begin
    res_val = N'(saturate(64'(acc >>> FRAC), N));
`ifdef RELU_EN
    if (res_val[N-1]) res_val = '0;
`else
`endif
  end

  // A write lands only while collecting and while the buffer has room.
  always_comb begin
    wr_en = 1'b0;
    if (state == COLLECT && res_write && cnt != CNT_W'(Q)) wr_en = 1'b1;
  end

  assign cnt_after = wr_en ? cnt + CNT_W'(1) : cnt;

  result_buf #(
    .N    (N),
    .Q    (Q),
    .IDX_W(IDX_W)
  ) u_result_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (cnt[IDX_W-1:0]),
    .wr_data(res_val),
    .rd_idx (rd_idx[IDX_W-1:0]),
    .rd_data(rd_data)
  );

  assign out_data = (state == DRAIN) ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= COLLECT;
      cnt       <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          cnt <= cnt_after;
          if (res_write && !wr_en) err <= 1'b1;
          // A res_write in the same cycle as done is included in the drain.
          if (done && cnt_after != '0) begin
            state     <= DRAIN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            rd_idx    <= '0;
            out_last  <= (cnt_after == CNT_W'(1));
          end
        end
        DRAIN: begin
          if (res_write) err <= 1'b1;
          if (out_ready) begin
            if (out_last) begin
              state     <= COLLECT;
              cnt       <= '0;
              rd_idx    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              rd_idx   <= rd_idx + CNT_W'(1);
              out_last <= (rd_idx + CNT_W'(2) == cnt);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_datapath.sv
// tb/tb_neuron_mac_datapath.sv - scoreboard testbench for neuron_mac_datapath
module tb_neuron_mac_datapath;

  localparam int N    = 8;
  localparam int D    = 4;
  localparam int Q    = 2;
  localparam int FRAC = 0;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic signed [N-1:0] x_in = '0;
  logic signed [N-1:0] w_in = '0;
  logic write_x = 1'b0, write_w = 1'b0, acc_write = 1'b0, clear_acc = 1'b0;
  logic res_write = 1'b0, done = 1'b0, out_ready = 1'b0;
  logic         out_valid, out_last, busy, err;
  logic [N-1:0] out_data;

  always #5 clk = ~clk;

  neuron_mac_datapath #(.N(N), .d(D), .Q(Q), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .w_in(w_in),
    .write_x(write_x), .write_w(write_w), .acc_write(acc_write),
    .clear_acc(clear_acc), .res_write(res_write), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {int data; bit last;} exp_t;
  exp_t exp_q[$];
  int   pend[$];
  int   mx, mw, macc;
  bit   model_err, drain_active, last_seen;
  int   ready_mode = 2;  // 0 random, 1 held low, 2 held high

  function automatic int conv(input int a);
    int s;
    s = a >>> FRAC;
    if (s > (1 << (N - 1)) - 1) s = (1 << (N - 1)) - 1;
    if (s < -(1 << (N - 1))) s = -(1 << (N - 1));
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    mx = 0; mw = 0; macc = 0;
    model_err = 0; drain_active = 0; last_seen = 0;
    pend.delete();
    exp_q.delete();
  endtask

  // One clock cycle of stimulus; the model advances right after the edge.
  task automatic step(input bit r, input bit wx, input bit ww, input bit aw,
                      input bit ca, input bit rw, input bit dn, input int xv, input int wv);
    int cur;
    exp_t e;
    rst = r; write_x = wx; write_w = ww; acc_write = aw; clear_acc = ca;
    res_write = rw; done = dn;
    x_in = N'(xv); w_in = N'(wv);
    out_ready = (ready_mode == 1) ? 1'b0 : (ready_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      cur = conv(macc);
      if (rw) begin
        if (drain_active || pend.size() == Q) model_err = 1;
        else pend.push_back(cur);
      end
      if (dn && !drain_active && pend.size() > 0) begin
        foreach (pend[i]) begin
          e.data = pend[i];
          e.last = (i == pend.size() - 1);
          exp_q.push_back(e);
        end
        pend.delete();
        drain_active = 1;
      end else if (last_seen) begin
        drain_active = 0;
      end
      last_seen = 0;
      if (ca) macc = aw ? mx * mw : 0;
      else if (aw) macc = macc + mx * mw;
      if (wx) mx = xv;
      if (ww) mw = wv;
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Loads d pairs back to back, accumulates them, then buffers the result.
  task automatic neuron(input int xs[D], input int ws[D]);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, xs[0], ws[0]);
    for (int i = 1; i < D; i++) step(1, 1, 1, 1, 0, 0, 0, xs[i], ws[i]);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (drain_active && n < 100) begin
      idle();
      n++;
    end
    tests++;
    if (drain_active || exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and tracks flags.
  initial begin
    exp_t e;
    bit prev_stall;
    logic [N-1:0] prev_data;
    logic prev_last;
    prev_stall = 0;
    prev_data = '0;
    prev_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("out_valid", int'(out_valid), int'(drain_active));
        check("busy", int'(busy), int'(drain_active));
        check("err", int'(err), int'(model_err));
        if (prev_stall) begin
          check("hold_data", int'(out_data), int'(prev_data));
          check("hold_last", int'(out_last), int'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %0d expected no beat", $signed(out_data));
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'($signed(out_data)), e.data);
            check("out_last", int'(out_last), int'(e.last));
            if (e.last) last_seen = 1;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    int xs[D];
    int ws[D];
    int nacc;
    bit ca, aw, rw, dn;
    model_reset();
    ready_mode = 2;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_last", int'(out_last), 0);

    // Sum 1+2+3+4
    xs = '{1, 2, 3, 4}; ws = '{1, 1, 1, 1};
    neuron(xs, ws);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    wait_drain();

    // Positive and negative saturation
    xs = '{127, 127, 127, 127}; ws = '{127, 127, 127, 127};
    neuron(xs, ws);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    wait_drain();
    xs = '{-128, -128, -128, -128};
    neuron(xs, ws);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    wait_drain();

    // Two neurons with downstream stalled for three cycles
    xs = '{1, 2, 3, 4}; ws = '{1, 1, 1, 1};
    neuron(xs, ws);
    xs = '{-5, 0, 0, 0};
    neuron(xs, ws);
    ready_mode = 1;
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(); idle(); idle();
    ready_mode = 2;
    wait_drain();

    // Overflow of the buffer, then res_write during drain
    xs = '{1, 1, 1, 1};
    neuron(xs, ws);
    neuron(xs, ws);
    neuron(xs, ws);
    ready_mode = 1;
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    ready_mode = 2;
    wait_drain();

    // clear_acc with acc_write: acc 50, then 3 * -2
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 10, 5);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 3, -2);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    wait_drain();

    // Reset in the middle of a drain, then done with nothing buffered
    neuron(xs, ws);
    neuron(xs, ws);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    ready_mode = 1;
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    check("rst_mid_drain_cnt_valid", int'(out_valid), 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(); idle();
    check("done_empty_busy", int'(busy), 0);
    ready_mode = 2;

    // Randomized strobes, never exceeding d accumulations per clear
    ready_mode = 0;
    nacc = 0;
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      ca = ($urandom_range(0, 7) == 0);
      aw = ($urandom_range(0, 1) == 1) && (ca || nacc < D);
      rw = ($urandom_range(0, 5) == 0);
      dn = ($urandom_range(0, 9) == 0);
      nacc = ca ? int'(aw) : nacc + int'(aw);
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aw, ca, rw, dn,
           $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
    end
    wait_drain();
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    wait_drain();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
